digit_scan_ctrl: RTL and testbench
==================================

// Module: digit_scan_ctrl
// PURPOSE
//  Upstream driver for the 3-to-8 decoder in the 8-digit seven-segment display path.
//  Stores eight 4-bit digit values and steps through the digits in time slots.
//  Each slot drives the decoder select {C,B,A} and enables (G1, not_G2, not_G3).
//  A guard blank at the start of each slot suppresses ghosting.
//  seg_code carries the selected digit value to the segment decoder.
// PARAMETERS
//  DIV    4  clock cycles per digit slot; legal range 2..65535
//  GUARD  1  blanked cycles at the start of each slot; legal range 0..DIV-1
// PORTS
//  clk         in   1  single clock; all logic on the rising edge
//  rst         in   1  synchronous, active-high reset
//  en          in   1  scan enable; level-sensitive
//  wr_en       in   1  digit register write strobe
//  wr_addr     in   3  digit index to write
//  wr_data     in   4  digit value to write
//  digit_mask  in   8  per-digit display enable; bit i = digit i
//  G1          out  1  decoder enable, active-high
//  not_G2      out  1  decoder enable, active-low
//  not_G3      out  1  decoder enable, active-low
//  A,B,C       out  1  decoder select; {C,B,A} = current digit index
//  seg_code    out  4  value of the current digit
//  frame_tick  out  1  one-cycle pulse when the index wraps 7->0
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, index=0, regfile all 0.
//  Reset outputs: G1=0, not_G2=1, not_G3=1, A=B=C=0, seg_code=0, frame_tick=0.
//  Reset takes effect on the next edge, from any state, including mid-slot.
//  All outputs are registered.
//  States: IDLE, BLANK, SHOW.
//  IDLE:
//   - not_G2=not_G3=1, G1=0; index and prescaler held at 0.
//   - If en=1 at an edge, the next state is BLANK (or SHOW if GUARD=0) with index 0.
//  BLANK/SHOW:
//   - not_G2=not_G3=0.
//   - G1=1 only in SHOW and only when digit_mask[index]=1; else G1=0.
//  Prescaler:
//   - Counts 0..DIV-1 within a slot.
//   - BLANK while prescaler<GUARD; SHOW for the remaining DIV-GUARD cycles.
//   - At prescaler=DIV-1: prescaler->0, index->index+1 mod 8, state->BLANK (SHOW if GUARD=0).
//  frame_tick is asserted the cycle after the 7->0 wrap; it never fires from IDLE start-up.
//  en=0 in any non-IDLE state: next edge goes to IDLE with reset-value outputs.
//   - index and prescaler clear to 0; regfile is kept.
//  digit_mask is sampled every cycle; a change takes effect on the next edge, even mid-slot.
//  Regfile write: on wr_en, regfile[wr_addr] <= wr_data at the edge, in any state.
//  seg_code <= regfile[next_index], write-first bypass:
//   - if wr_en and wr_addr==next_index, seg_code <= wr_data;
//   - so a write to the showing digit is visible on the next cycle.
//  seg_code is updated in IDLE too, using index 0.
// STRUCTURE
//  Package scan_pkg:
//   - typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;
//   - localparam NDIG=8, IDXW=3, DW=4.
//  Sub-module digit_regfile: 8x4 storage, synchronous write, combinational read with write-first bypass.
//  Top level holds the FSM, prescaler, index counter and output registers.
// TESTING (DIV=4, GUARD=1 unless stated)
//  1. Reset, then en=1, mask=FF:
//     - G1 pattern per slot is 0,1,1,1;
//     - {C,B,A} runs 0..7,0;
//     - frame_tick is high exactly once per 32 cycles.
//  2. Write wr_addr=3, data=A while index=3 is in SHOW -> seg_code=A on the next cycle.
//     Also write addr 5 -> seg_code=5's value when index reaches 5.
//  3. mask=8'b1111_0111 -> G1 stays 0 for the whole index-3 slot; other digits unaffected.
//  4. en dropped mid-slot at index 5 -> next cycle: G1=0, not_G2=not_G3=1, {C,B,A}=0.
//     Re-enable restarts at index 0 with regfile contents intact.
//  5. rst asserted during SHOW at index 6 -> next cycle all outputs at reset values and regfile=0.
//  6. GUARD=0, DIV=2 -> G1 stays 1 continuously; index advances every 2 cycles.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and sizes for the seven-segment digit scanner.
package scan_pkg;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

  localparam int unsigned NDIG = 8;
  localparam int unsigned IDXW = 3;
  localparam int unsigned DW   = 4;
  localparam int unsigned PW   = 16;

endpackage

// File: rtl/digit_regfile.sv
// Eight 4-bit digit registers: synchronous write, combinational read with
// write-first bypass so a same-cycle write is seen by the reader.
module digit_regfile
  import scan_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_wr_en,
  input  logic [IDXW-1:0] i_wr_addr,
  input  logic [DW-1:0]   i_wr_data,
  input  logic [IDXW-1:0] i_rd_addr,
  output logic [DW-1:0]   o_rd_data
);

  logic [DW-1:0] r_mem [NDIG];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data = r_mem[i_rd_addr];
    if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
      o_rd_data = i_wr_data;
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-slot scanner driving a 3-to-8 digit decoder: per-slot guard blank,
// per-digit mask, frame tick on the 7->0 index wrap.
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int GUARD = 1
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [3:0]    wr_data,
  input  logic [7:0]    digit_mask,
  output logic          G1,
  output logic          not_G2,
  output logic          not_G3,
  output logic          A,
  output logic          B,
  output logic          C,
  output logic [3:0]    seg_code,
  output logic          frame_tick
);

  localparam logic [PW-1:0] LP_LAST = PW'(DIV - 1);

  scan_state_t     r_state, w_state_nxt;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  logic [IDXW-1:0] r_index, w_index_nxt;
  logic            w_wrap;
  logic [DW-1:0]   w_rd_data;

  logic            r_g1;
  logic            r_ng;
  logic [IDXW-1:0] r_sel;
  logic [DW-1:0]   r_seg;
  logic            r_ft;

  digit_regfile u_regfile (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (w_index_nxt),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_presc <= '0;
      r_index <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_index <= w_index_nxt;
    end
  end

  // Slot phase alone decides BLANK vs SHOW, so IDLE start-up and slot
  // rollover share the same path through prescaler 0.
  always_comb begin
    w_state_nxt = IDLE;
    w_presc_nxt = '0;
    w_index_nxt = '0;
    w_wrap      = 1'b0;
    if (en) begin
      if (r_state != IDLE) begin
        if (r_presc == LP_LAST) begin
          w_index_nxt = r_index + 1'b1;
          w_wrap      = (r_index == IDXW'(NDIG - 1));
        end else begin
          w_presc_nxt = r_presc + 1'b1;
          w_index_nxt = r_index;
        end
      end
      w_state_nxt = (int'(w_presc_nxt) < GUARD) ? BLANK : SHOW;
    end
  end

  // Outputs are registered from the next-state decode so they line up
  // with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_g1  <= 1'b0;
      r_ng  <= 1'b1;
      r_sel <= '0;
      r_seg <= '0;
      r_ft  <= 1'b0;
    end else begin
      r_g1  <= (w_state_nxt == SHOW) && digit_mask[w_index_nxt];
      r_ng  <= (w_state_nxt == IDLE);
      r_sel <= w_index_nxt;
      r_seg <= w_rd_data;
      r_ft  <= w_wrap;
    end
  end

  assign G1          = r_g1;
  assign not_G2      = r_ng;
  assign not_G3      = r_ng;
  assign {C, B, A}   = r_sel;
  assign seg_code    = r_seg;
  assign frame_tick  = r_ft;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: time-since-enable model checked every cycle on
// two instances (DIV=4/GUARD=1 and DIV=2/GUARD=0) plus directed literals.
module tb_digit_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [7:0] mask = 8'hFF;

  logic       g1_a, ng2_a, ng3_a, a_a, b_a, c_a, ft_a;
  logic [3:0] seg_a;
  logic       g1_b, ng2_b, ng3_b, a_b, b_b, c_b, ft_b;
  logic [3:0] seg_b;

  always #5 clk = ~clk;

  digit_scan_ctrl #(.DIV(4), .GUARD(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .digit_mask(mask), .G1(g1_a), .not_G2(ng2_a),
    .not_G3(ng3_a), .A(a_a), .B(b_a), .C(c_a), .seg_code(seg_a),
    .frame_tick(ft_a)
  );

  digit_scan_ctrl #(.DIV(2), .GUARD(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .digit_mask(mask), .G1(g1_b), .not_G2(ng2_b),
    .not_G3(ng3_b), .A(a_b), .B(b_b), .C(c_b), .seg_code(seg_b),
    .frame_tick(ft_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles elapsed since scanning started, plus a shadow regfile.
  bit         m_valid  = 1'b0;
  bit         m_active = 1'b0;
  int         m_t      = 0;
  logic [7:0] m_mask   = 8'hFF;
  logic [3:0] mrf [8];

  always @(posedge clk) begin
    m_valid = 1'b1;
    m_mask  = mask;
    if (rst) begin
      m_active = 1'b0;
      m_t      = 0;
      foreach (mrf[i]) mrf[i] = '0;
    end else begin
      if (!en) begin
        m_active = 1'b0;
        m_t      = 0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_t      = 0;
      end else begin
        m_t++;
      end
      if (wr_en) mrf[wr_addr] = wr_data;
    end
  end

  task automatic check_unit(input string tag, input int div, input int guard,
                            input logic g1, input logic ng2, input logic ng3,
                            input logic [2:0] sel, input logic [3:0] seg,
                            input logic ft);
    int idx;
    int ph;
    idx = m_active ? (m_t / div) % 8 : 0;
    ph  = m_t % div;
    chk({tag, ".G1"},    int'(g1),  int'(m_active && ph >= guard && m_mask[idx]));
    chk({tag, ".nG2"},   int'(ng2), int'(!m_active));
    chk({tag, ".nG3"},   int'(ng3), int'(!m_active));
    chk({tag, ".sel"},   int'(sel), idx);
    chk({tag, ".seg"},   int'(seg), int'(mrf[idx]));
    chk({tag, ".frame"}, int'(ft),  int'(m_active && m_t > 0 && (m_t % (8 * div)) == 0));
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check_unit("A", 4, 1, g1_a, ng2_a, ng3_a, {c_a, b_a, a_a}, seg_a, ft_a);
      check_unit("B", 2, 0, g1_b, ng2_b, ng3_b, {c_b, b_b, a_b}, seg_b, ft_b);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".G1"},   int'(g1_a), 0);
    chk({tag, ".nG2"},  int'(ng2_a), 1);
    chk({tag, ".nG3"},  int'(ng3_a), 1);
    chk({tag, ".sel"},  int'({c_a, b_a, a_a}), 0);
    chk({tag, ".seg"},  int'(seg_a), 0);
    chk({tag, ".frame"}, int'(ft_a), 0);
  endtask

  initial begin
    int ft_cnt;
    int b_low;
    int hi3;

    cyc(2);
    rst = 1'b0;
    chk_reset_vals("reset");

    // Scan from start-up, one full frame and one tick.
    en = 1'b1;
    mask = 8'hFF;
    ft_cnt = 0;
    b_low = 0;
    for (int k = 0; k <= 32; k++) begin
      cyc(1);
      if (k > 0 && ft_a) ft_cnt++;
      if (!g1_b) b_low++;
      case (k)
        0: begin
          chk("scan.g1_k0", int'(g1_a), 0);
          chk("scan.sel_k0", int'({c_a, b_a, a_a}), 0);
          chk("scan.ng2_k0", int'(ng2_a), 0);
          chk("scan.ft_k0", int'(ft_a), 0);
        end
        1: chk("scan.g1_k1", int'(g1_a), 1);
        3: begin
          chk("scan.g1_k3", int'(g1_a), 1);
          chk("fast.sel_k3", int'({c_b, b_b, a_b}), 1);
        end
        4: begin
          chk("scan.g1_k4", int'(g1_a), 0);
          chk("scan.sel_k4", int'({c_a, b_a, a_a}), 1);
          chk("fast.sel_k4", int'({c_b, b_b, a_b}), 2);
        end
        31: chk("scan.sel_k31", int'({c_a, b_a, a_a}), 7);
        32: begin
          chk("scan.sel_k32", int'({c_a, b_a, a_a}), 0);
          chk("scan.ft_k32", int'(ft_a), 1);
          chk("model.t_k32", m_t, 32);
        end
        default: ;
      endcase
    end
    chk("scan.ft_count", ft_cnt, 1);
    chk("fast.g1_low_count", b_low, 0);

    // Write to the showing digit (index 3, t=45) then to digit 5.
    cyc(13);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hA;
    cyc(1);
    chk("wr.seg_show3", int'(seg_a), 10);
    wr_addr = 3'd5; wr_data = 4'h7;
    cyc(1);
    chk("wr.seg_still3", int'(seg_a), 10);
    wr_en = 1'b0;
    cyc(5);
    chk("wr.sel5", int'({c_a, b_a, a_a}), 5);
    chk("wr.seg5", int'(seg_a), 7);

    // Mask digit 3 (t=52 -> 81).
    mask = 8'b1111_0111;
    hi3 = 0;
    for (int tt = 53; tt <= 81; tt++) begin
      cyc(1);
      if (tt >= 76 && tt <= 79 && g1_a) hi3++;
      if (tt == 75) chk("mask.g1_idx2", int'(g1_a), 1);
      if (tt == 81) chk("mask.g1_idx4", int'(g1_a), 1);
    end
    chk("mask.g1_idx3_count", hi3, 0);
    mask = 8'hFF;

    // Drop enable mid-slot at index 5 (t=86).
    cyc(5);
    chk("drop.g1_before", int'(g1_a), 1);
    chk("drop.sel_before", int'({c_a, b_a, a_a}), 5);
    en = 1'b0;
    cyc(1);
    chk_reset_vals("drop");
    cyc(2);
    en = 1'b1;
    cyc(1);
    chk("reen.sel", int'({c_a, b_a, a_a}), 0);
    chk("reen.ng2", int'(ng2_a), 0);
    chk("reen.g1", int'(g1_a), 0);
    chk("reen.ft", int'(ft_a), 0);
    cyc(13);
    chk("reen.seg3", int'(seg_a), 10);
    cyc(8);
    chk("reen.seg5", int'(seg_a), 7);

    // Reset during SHOW at index 6 (t=26).
    cyc(5);
    chk("rst6.g1_before", int'(g1_a), 1);
    chk("rst6.sel_before", int'({c_a, b_a, a_a}), 6);
    rst = 1'b1;
    cyc(1);
    chk_reset_vals("rst6");
    rst = 1'b0;
    cyc(14);
    chk("rst6.sel3", int'({c_a, b_a, a_a}), 3);
    chk("rst6.seg3", int'(seg_a), 0);
    cyc(8);
    chk("rst6.seg5", int'(seg_a), 0);

    cyc(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
